// File: rtl/fpu_issue.sv
// Issue stage in front of the FPU: takes one decoded request, drives a one-hot
// unit select until the result (or a timeout) arrives, then hands it to writeback.
module fpu_issue #(
  parameter int TIMEOUT = 256,
  parameter int RD_W    = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [3:0]      req_cmp,
  input  logic [RD_W-1:0] req_rd,
  output logic [9:0]      fpu_in_valid,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  output logic [3:0]      fpu_cmp,
  input  logic [31:0]     fpu_out,
  input  logic            fpu_out_valid,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_err,
  output logic            busy
);

  // Handshakes: a transfer happens on any rising edge where valid and ready
  // are both high; valid is never withdrawn and its payload never changes
  // until that transfer has taken place.

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] OP_FMOV = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [3:0]      op_q;
  logic [CW-1:0]   cnt, cnt_n;
  logic [31:0]     wb_data_n;
  logic            wb_err_n;
  logic            accept;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    wb_data_n = wb_data;
    wb_err_n  = wb_err;
    req_ready = 1'b0;
    wb_valid  = 1'b0;
    busy      = 1'b1;
    fpu_in_valid = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          cnt_n = '0;
          if (req_op < OP_FMOV) begin
            state_n = BUSY;
          end else if (req_op == OP_FMOV) begin
            state_n   = WB;
            wb_data_n = req_a;
            wb_err_n  = 1'b0;
          end else begin
            state_n   = WB;
            wb_data_n = '0;
            wb_err_n  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (op_q < OP_FMOV) fpu_in_valid = 10'b1 << op_q;
        // A result arriving on the last allowed cycle beats the timeout.
        if (fpu_out_valid) begin
          state_n   = WB;
          wb_data_n = fpu_out;
          wb_err_n  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n   = WB;
          wb_data_n = '0;
          wb_err_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      fpu_a   <= '0;
      fpu_b   <= '0;
      fpu_cmp <= '0;
      wb_data <= '0;
      wb_rd   <= '0;
      wb_err  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      wb_data <= wb_data_n;
      wb_err  <= wb_err_n;
      if (accept) begin
        op_q    <= req_op;
        fpu_a   <= req_a;
        fpu_b   <= req_b;
        fpu_cmp <= req_cmp;
        wb_rd   <= req_rd;
      end
    end
  end

endmodule
